// File: rtl/weight_load_ctrl.sv
`default_nettype none
// ============================================================================
// weight_load_ctrl : steps the weight ROM through every filter and streams the
//                    packed words out through a 3-entry credit-gated FIFO.
// Revision 1.0
// ============================================================================
module weight_load_ctrl #(
   parameter int BW       = 8,
   parameter int SIZE     = 26,
   parameter int NUM_FILT = 6,
   parameter int AW       = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_rom_read_en,
   output logic [AW-1:0]      o_rom_addr,
   input  logic [BW*SIZE-1:0] i_rom_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW*SIZE-1:0] o_weight_data,
   output logic [AW-1:0]      o_filt_idx
);

   localparam int            c_DW       = BW*SIZE;
   localparam logic [1:0]    c_S_IDLE   = 2'd0;
   localparam logic [1:0]    c_S_RUN    = 2'd1;
   localparam logic [1:0]    c_S_DONE   = 2'd2;
   localparam logic [AW:0]   c_NUM_FILT = (AW+1)'(NUM_FILT);
   localparam logic [AW-1:0] c_LAST_IDX = AW'(NUM_FILT-1);

   logic [1:0]      r_state;
   logic [AW:0]     r_issued;
   logic            r_rd_d1;
   logic [AW-1:0]   r_addr_d1;
   logic [c_DW-1:0] r_mem [0:2];
   logic [AW-1:0]   r_idx [0:2];
   logic [1:0]      r_wr_ptr;
   logic [1:0]      r_rd_ptr;
   logic [1:0]      r_count;

   logic            w_push;
   logic            w_pop;
   logic [2:0]      w_count_next;
   logic [2:0]      w_credit;
   logic            w_issue;

   function automatic logic [1:0] f_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // ROM data captured at the edge after a read-enable cycle is pushed one edge later
   assign w_push        = r_rd_d1;
   assign w_pop         = o_valid & i_ready;
   assign w_count_next  = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};
   assign w_credit      = w_count_next + {2'b00, o_rom_read_en};
   assign w_issue       = (r_state == c_S_RUN) && (r_issued < c_NUM_FILT) && (w_credit < 3'd3);

   assign o_valid       = (r_count != 2'd0);
   assign o_weight_data = r_mem[r_rd_ptr];
   assign o_filt_idx    = r_idx[r_rd_ptr];
   assign o_busy        = (r_state == c_S_RUN);
   assign o_done        = (r_state == c_S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= c_S_IDLE;
         r_issued      <= '0;
         o_rom_read_en <= 1'b0;
         o_rom_addr    <= '0;
         r_rd_d1       <= 1'b0;
         r_addr_d1     <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         for (int i = 0; i < 3; i++) begin
            r_mem[i] <= '0;
            r_idx[i] <= '0;
         end
      end else begin
         r_rd_d1   <= o_rom_read_en;
         r_addr_d1 <= o_rom_addr;
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_rom_data;
            r_idx[r_wr_ptr] <= r_addr_d1;
            r_wr_ptr        <= f_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_inc(r_rd_ptr);
         end
         r_count <= w_count_next[1:0];

         case (r_state)
            c_S_IDLE: begin
               if (i_start) begin
                  r_state       <= c_S_RUN;
                  o_rom_read_en <= 1'b1;
                  o_rom_addr    <= '0;
                  r_issued      <= (AW+1)'(1);
               end else begin
                  o_rom_read_en <= 1'b0;
               end
            end
            c_S_RUN: begin
               o_rom_read_en <= w_issue;
               if (w_issue) begin
                  o_rom_addr <= r_issued[AW-1:0];
                  r_issued   <= r_issued + (AW+1)'(1);
               end
               if (w_pop && (o_filt_idx == c_LAST_IDX)) begin
                  r_state <= c_S_DONE;
               end
            end
            c_S_DONE: begin
               r_state       <= c_S_IDLE;
               o_rom_read_en <= 1'b0;
            end
            default: begin
               r_state       <= c_S_IDLE;
               o_rom_read_en <= 1'b0;
            end
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && (r_count == 2'd3)));

endmodule
`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for weight_load_ctrl: random ROM content and backpressure,
// plus a NUM_FILT=1 instance for the single-filter corner.
module tb_weight_load_ctrl;

   localparam int BW   = 8;
   localparam int SIZE = 26;
   localparam int NF   = 6;
   localparam int AW   = 3;
   localparam int DW   = BW*SIZE;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [AW-1:0] i;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic ready = 1'b0;
   logic busy, done, rd_en, valid;
   logic [AW-1:0] addr, idx;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rom [0:NF-1];
   logic [DW-1:0] rom_q;

   logic start1 = 1'b0;
   logic ready1 = 1'b1;
   logic busy1, done1, rd_en1, valid1;
   logic [0:0] addr1, idx1;
   logic [DW-1:0] wdata1;
   logic [DW-1:0] rom1;
   logic [DW-1:0] rom1_q;

   ent_t exp_q [$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   rd_tot = 0;
   int   pop_tot = 0;
   int   done_tot = 0;
   int   seq_rd = 0;
   logic hold_v = 1'b0;
   logic [DW-1:0] hold_d;
   logic [AW-1:0] hold_i;

   always #5 clk = ~clk;

   weight_load_ctrl #(.BW(BW), .SIZE(SIZE), .NUM_FILT(NF), .AW(AW)) dut (
      .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
      .o_rom_read_en(rd_en), .o_rom_addr(addr), .i_rom_data(rom_q),
      .o_valid(valid), .i_ready(ready), .o_weight_data(wdata), .o_filt_idx(idx)
   );

   weight_load_ctrl #(.BW(BW), .SIZE(SIZE), .NUM_FILT(1), .AW(1)) dut1 (
      .clk(clk), .rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
      .o_rom_read_en(rd_en1), .o_rom_addr(addr1), .i_rom_data(rom1_q),
      .o_valid(valid1), .i_ready(ready1), .o_weight_data(wdata1), .o_filt_idx(idx1)
   );

   // Registered ROM models: data appears the cycle after a read enable
   always @(posedge clk) begin
      if (rd_en) rom_q <= (int'(addr) < NF) ? rom[addr] : '0;
      if (rd_en1) rom1_q <= rom1;
   end

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples mid-cycle, so o_valid & i_ready here is the handshake of the next edge
   always @(negedge clk) begin
      ent_t e;
      if (rst) begin
         hold_v  = 1'b0;
         pop_tot = rd_tot;
         seq_rd  = 0;
      end else begin
         if (rd_en) begin
            chk("rd_addr_order", DW'(addr), DW'(seq_rd));
            seq_rd++;
            rd_tot++;
            chk("read_credit", DW'((rd_tot - pop_tot) <= 3), DW'(1));
         end
         if (hold_v) begin
            chk("hold_valid", DW'(valid), DW'(1));
            chk("hold_data", wdata, hold_d);
            chk("hold_idx", DW'(idx), DW'(hold_i));
         end
         hold_v = valid && !ready;
         hold_d = wdata;
         hold_i = idx;
         if (valid && ready) begin
            pop_tot++;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", DW'(idx), DW'(NF));
            end else begin
               e = exp_q.pop_front();
               chk("sb_data", wdata, e.d);
               chk("sb_idx", DW'(idx), DW'(e.i));
            end
         end
         if (done) begin
            done_tot++;
            chk("done_all_read", DW'(seq_rd), DW'(NF));
            chk("done_all_popped", DW'(exp_q.size()), DW'(0));
            seq_rd = 0;
         end
      end
   end

   task automatic fill_rom(input bit directed);
      for (int k = 0; k < NF; k++)
         for (int e = 0; e < SIZE; e++)
            rom[k][e*BW +: BW] = directed ? BW'(8'h10 + k) : BW'($urandom);
      for (int k = 0; k < NF; k++)
         exp_q.push_back('{d: rom[k], i: AW'(k)});
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, DW'(busy), DW'(0));
      chk({tag, "_done"}, DW'(done), DW'(0));
      chk({tag, "_rd_en"}, DW'(rd_en), DW'(0));
      chk({tag, "_addr"}, DW'(addr), DW'(0));
      chk({tag, "_valid"}, DW'(valid), DW'(0));
      chk({tag, "_data"}, wdata, DW'(0));
      chk({tag, "_idx"}, DW'(idx), DW'(0));
   endtask

   // Free-running cycle-exact sequence; k indexes the cycle after edge Ek
   task automatic test_free_run;
      fill_rom(1'b1);
      ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("fr_rd_en_k%0d", k), DW'(rd_en), DW'(k <= 5));
         chk($sformatf("fr_valid_k%0d", k), DW'(valid), DW'(k >= 2 && k <= 7));
         chk($sformatf("fr_done_k%0d", k), DW'(done), DW'(k == 8));
         chk($sformatf("fr_busy_k%0d", k), DW'(busy), DW'(k <= 7));
         tick;
      end
   endtask

   // mode 0: ready high; 1: random ready; 2: stalled for 8 cycles; 3: random ready + stray starts
   task automatic run_seq(input int mode);
      int d0;
      int t;
      fill_rom(1'b0);
      d0 = done_tot;
      ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      start = 1'b1;
      tick;
      start = 1'b0;
      t = 0;
      while (!done && t < 500) begin
         if (mode == 2 && t == 6) begin
            chk("stall_reads", DW'(seq_rd), DW'(3));
            chk("stall_valid", DW'(valid), DW'(1));
            chk("stall_idx", DW'(idx), DW'(0));
         end
         start = (mode == 3 && t == 2);
         case (mode)
            0:       ready = 1'b1;
            2:       ready = (t >= 7);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         tick;
         t++;
      end
      chk("seq_timeout", DW'(t < 500), DW'(1));
      start = (mode == 3);
      tick;
      start = 1'b0;
      chk("seq_one_done", DW'(done_tot - d0), DW'(1));
      if (mode == 3) begin
         tick; tick;
         chk("ignored_start_busy", DW'(busy), DW'(0));
         chk("ignored_start_rd_en", DW'(rd_en), DW'(0));
      end
      if (t >= 500) begin
         rst = 1'b1; tick; rst = 1'b0; exp_q.delete(); tick;
      end
   endtask

   task automatic test_mid_reset;
      fill_rom(1'b0);
      ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick; tick;
      rst = 1'b1;
      tick;
      chk_zero_outputs("midrst");
      exp_q.delete();
      rst = 1'b0;
      tick; tick;
      chk_zero_outputs("post_rst_idle");
      run_seq(0);
   endtask

   task automatic test_single;
      for (int e = 0; e < SIZE; e++) rom1[e*BW +: BW] = BW'($urandom);
      ready1 = 1'b1;
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      chk("n1_rd_en_k0", DW'(rd_en1), DW'(1));
      chk("n1_addr_k0", DW'(addr1), DW'(0));
      chk("n1_busy_k0", DW'(busy1), DW'(1));
      tick;
      chk("n1_rd_en_k1", DW'(rd_en1), DW'(0));
      chk("n1_valid_k1", DW'(valid1), DW'(0));
      tick;
      chk("n1_valid_k2", DW'(valid1), DW'(1));
      chk("n1_data_k2", wdata1, rom1);
      chk("n1_idx_k2", DW'(idx1), DW'(0));
      tick;
      chk("n1_valid_k3", DW'(valid1), DW'(0));
      chk("n1_done_k3", DW'(done1), DW'(1));
      chk("n1_busy_k3", DW'(busy1), DW'(0));
      tick;
      chk("n1_done_k4", DW'(done1), DW'(0));
   endtask

   initial begin
      rst = 1'b1;
      tick; tick; tick;
      chk_zero_outputs("reset");
      rst = 1'b0;
      tick;
      test_free_run();
      run_seq(2);
      run_seq(3);
      test_mid_reset();
      for (int s = 0; s < 200; s++) run_seq(1);
      test_single();
      tick; tick;
      chk("final_queue_empty", DW'(exp_q.size()), DW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
